// File: rtl/reaction_pkg.sv
// reaction_pkg: shared FSM state type, default parameters and hold-counter width helper
package reaction_pkg;
  typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, GO, DONE, FOUL} state_t;
  localparam int N_LIGHTS_DEF = 5;
  localparam int STEP_MS_DEF = 500;
  localparam int MIN_HOLD_MS_DEF = 200;
  localparam int HOLD_SCALE_MS_DEF = 32;
  localparam int RAND_W_DEF = 5;
  localparam int RT_W_DEF = 14;
  function automatic int hold_w(input int min_hold, input int scale, input int rw);
    int w;
    w = $clog2(min_hold + ((1 << rw) - 1) * scale + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/ms_down_counter.sv
// ms_down_counter: loadable tick-enabled down-counter that stops at zero and flags it
module ms_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         tick,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else count <= load ? load_val : (tick && !zero) ? count - 1'b1 : count;
  assign zero = count == '0;
endmodule

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: lamp-bar reaction-test round FSM; REACTION_BEST_EN adds best_ms tracking
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int N_LIGHTS      = N_LIGHTS_DEF,
  parameter int STEP_MS       = STEP_MS_DEF,
  parameter int MIN_HOLD_MS   = MIN_HOLD_MS_DEF,
  parameter int HOLD_SCALE_MS = HOLD_SCALE_MS_DEF,
  parameter int RAND_W        = RAND_W_DEF,
  parameter int RT_W          = RT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_ms,
  input  logic                start,
  input  logic                react,
  input  logic [RAND_W-1:0]   rnd,
  output logic [N_LIGHTS-1:0] lights,
  output logic [RT_W-1:0]     react_ms,
  output logic                valid,
  output logic                false_start,
  output logic                timeout,
  output logic                busy
`ifdef REACTION_BEST_EN
  , output logic [RT_W-1:0]   best_ms
`endif
);
  localparam int HW = hold_w(MIN_HOLD_MS, HOLD_SCALE_MS, RAND_W);
  localparam int SW = $clog2(STEP_MS + 1);
  state_t state, state_nx;
  logic [N_LIGHTS-1:0] lights_nx;
  logic [RT_W-1:0] rt_nx;
  logic valid_nx, fs_nx, to_nx, step_load, hold_load, step_zero, hold_zero;
  logic [HW-1:0] h_val, h_ld;
  assign h_val = HW'(MIN_HOLD_MS) + HW'(rnd) * HW'(HOLD_SCALE_MS);
  assign h_ld = (h_val == '0) ? '0 : h_val - 1'b1;
  assign busy = (state == LIGHTS) || (state == HOLD) || (state == GO);
  ms_down_counter #(.W(SW)) u_step (
    .clk(clk), .rst_n(rst_n), .load(step_load), .tick(tick_ms && state == LIGHTS),
    .load_val(SW'(STEP_MS - 1)), .zero(step_zero)
  );
  ms_down_counter #(.W(HW)) u_hold (
    .clk(clk), .rst_n(rst_n), .load(hold_load), .tick(tick_ms && state == HOLD),
    .load_val(h_ld), .zero(hold_zero)
  );
  always_comb begin
    state_nx = state;
    lights_nx = lights;
    rt_nx = react_ms;
    valid_nx = valid;
    fs_nx = false_start;
    to_nx = timeout;
    step_load = 1'b0;
    hold_load = 1'b0;
    case (state)
      IDLE, DONE, FOUL: if (start) begin
        state_nx = LIGHTS;
        lights_nx = '0;
        rt_nx = '0;
        valid_nx = 1'b0;
        fs_nx = 1'b0;
        to_nx = 1'b0;
        step_load = 1'b1;
      end
      LIGHTS, HOLD: if (react) begin
        state_nx = FOUL;
        fs_nx = 1'b1;
        lights_nx = '1;
        rt_nx = '0;
      end else if (state == LIGHTS && tick_ms && step_zero) begin
        lights_nx = {lights[N_LIGHTS-2:0], 1'b1};
        step_load = 1'b1;
        state_nx = (&lights_nx) ? HOLD : LIGHTS;
        hold_load = &lights_nx;
      end else if (state == HOLD && tick_ms && hold_zero) begin
        state_nx = GO;
        lights_nx = '0;
      end
      GO: if (react) begin
        state_nx = DONE;
        valid_nx = 1'b1;
      end else if (tick_ms) begin
        rt_nx = react_ms + 1'b1;
        state_nx = (&rt_nx) ? DONE : GO;
        to_nx = &rt_nx;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      lights <= '0;
      react_ms <= '0;
      valid <= 1'b0;
      false_start <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      lights <= lights_nx;
      react_ms <= rt_nx;
      valid <= valid_nx;
      false_start <= fs_nx;
      timeout <= to_nx;
    end
`ifdef REACTION_BEST_EN
  always_ff @(posedge clk)
    if (!rst_n) best_ms <= '1;
    else if (state == GO && state_nx == DONE && valid_nx && rt_nx < best_ms) best_ms <= rt_nx;
`endif
endmodule
